// File: rtl/pixel_fifo_ctrl.sv
// 256-deep x 12-bit pixel FIFO controller driving an external 1-cycle-latency EBR.
// Define PIXEL_FIFO_ALMOST_FULL_EN to add the registered o_almost_full output.
module pixel_fifo_ctrl #(
  parameter int unsigned ALMOST_FULL_THRESH = 240
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_valid,
  input  logic [11:0] i_wr_data,
  output logic        o_wr_ready,
  output logic        o_rd_valid,
  output logic [11:0] o_rd_data,
  input  logic        i_rd_ready,
  output logic        o_ram_we,
  output logic [7:0]  o_ram_waddr,
  output logic [11:0] o_ram_wdata,
  output logic        o_ram_re,
  output logic [7:0]  o_ram_raddr,
  input  logic [11:0] i_ram_rdata,
  output logic [8:0]  o_count
`ifdef PIXEL_FIFO_ALMOST_FULL_EN
  ,
  output logic        o_almost_full
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
  } rd_state_e;

  rd_state_e  state_q, state_d;
  logic [8:0] wptr_q, wptr_d;
  logic [8:0] fptr_q, fptr_d;
  logic [8:0] count_q, count_d;

  logic wr_ready;
  logic wr_hs;
  logic rd_valid;
  logic rd_hs;
  logic avail;
  logic fetch;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      fptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      fptr_q  <= fptr_d;
      count_q <= count_d;
    end
  end

  // Fetch eligibility uses registered wptr, so a slot written this cycle is
  // never read back until the next one (no read-during-write on the EBR).
  always_comb begin
    wr_ready = (count_q != 9'd256);
    wr_hs    = i_wr_valid & wr_ready & ~i_rst;
    rd_valid = (state_q != S_IDLE);
    rd_hs    = rd_valid & i_rd_ready & ~i_rst;
    avail    = (wptr_q != fptr_q);
    fetch    = avail & ~i_rst & ((state_q == S_IDLE) | rd_hs);

    state_d  = state_q;
    wptr_d   = wptr_q;
    fptr_d   = fptr_q;
    count_d  = count_q;

    if (fetch) begin
      state_d = S_FETCH;
    end else if (state_q == S_IDLE || rd_hs) begin
      state_d = S_IDLE;
    end else begin
      state_d = S_HOLD;
    end

    if (wr_hs) begin
      wptr_d = wptr_q + 9'd1;
    end
    if (fetch) begin
      fptr_d = fptr_q + 9'd1;
    end

    case ({wr_hs, rd_hs})
      2'b10:   count_d = count_q + 9'd1;
      2'b01:   count_d = count_q - 9'd1;
      default: count_d = count_q;
    endcase
  end

  assign o_wr_ready  = wr_ready;
  assign o_rd_valid  = rd_valid;
  assign o_rd_data   = i_ram_rdata;
  assign o_ram_we    = wr_hs;
  assign o_ram_waddr = wptr_q[7:0];
  assign o_ram_wdata = i_wr_data;
  assign o_ram_re    = fetch;
  assign o_ram_raddr = fptr_q[7:0];
  assign o_count     = count_q;

`ifdef PIXEL_FIFO_ALMOST_FULL_EN
  localparam logic [8:0] THRESH_W = 9'(ALMOST_FULL_THRESH);

  logic almost_full_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (count_q >= THRESH_W);
    end
  end

  assign o_almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_pixel_fifo_ctrl.sv
// Scoreboard bench for pixel_fifo_ctrl with a behavioural 256x12 EBR model.
module tb_pixel_fifo_ctrl;

  logic        clk;
  logic        i_rst;
  logic        i_wr_valid;
  logic [11:0] i_wr_data;
  logic        o_wr_ready;
  logic        o_rd_valid;
  logic [11:0] o_rd_data;
  logic        i_rd_ready;
  logic        o_ram_we;
  logic [7:0]  o_ram_waddr;
  logic [11:0] o_ram_wdata;
  logic        o_ram_re;
  logic [7:0]  o_ram_raddr;
  logic [11:0] i_ram_rdata;
  logic [8:0]  o_count;
`ifdef PIXEL_FIFO_ALMOST_FULL_EN
  logic        o_almost_full;
`endif

  pixel_fifo_ctrl #(.ALMOST_FULL_THRESH(240)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_wr_valid  (i_wr_valid),
    .i_wr_data   (i_wr_data),
    .o_wr_ready  (o_wr_ready),
    .o_rd_valid  (o_rd_valid),
    .o_rd_data   (o_rd_data),
    .i_rd_ready  (i_rd_ready),
    .o_ram_we    (o_ram_we),
    .o_ram_waddr (o_ram_waddr),
    .o_ram_wdata (o_ram_wdata),
    .o_ram_re    (o_ram_re),
    .o_ram_raddr (o_ram_raddr),
    .i_ram_rdata (i_ram_rdata),
    .o_count     (o_count)
`ifdef PIXEL_FIFO_ALMOST_FULL_EN
    ,
    .o_almost_full (o_almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // EBR model: 1-cycle read latency, output held while RE is low.
  logic [11:0] mem [256];
  initial i_ram_rdata = '0;
  always @(posedge clk) begin
    if (o_ram_we) mem[o_ram_waddr] <= o_ram_wdata;
    if (o_ram_re) i_ram_rdata <= mem[o_ram_raddr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and monitor
  logic [11:0] sb [$];
  int          mcount = 0;
  logic [7:0]  mwaddr = '0;
  logic        prev_stall = 1'b0;
  logic [11:0] prev_data  = '0;

  always @(negedge clk) begin
    logic wr, rd;
    logic [11:0] exp_px;
    if (i_rst) begin
      sb.delete();
      mcount     = 0;
      mwaddr     = '0;
      prev_stall = 1'b0;
    end else begin
      wr = i_wr_valid && (mcount != 256);
      rd = o_rd_valid && i_rd_ready;
      chk("count", 32'(o_count), 32'(mcount));
      chk("wr_ready", 32'(o_wr_ready), 32'(mcount != 256));
      chk("ram_we", 32'(o_ram_we), 32'(wr));
      if (wr) begin
        chk("ram_waddr", 32'(o_ram_waddr), 32'(mwaddr));
        chk("ram_wdata", 32'(o_ram_wdata), 32'(i_wr_data));
        sb.push_back(i_wr_data);
        mwaddr = mwaddr + 8'd1;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(o_rd_valid), 32'd1);
        chk("stall_data", 32'(o_rd_data), 32'(prev_data));
      end
      if (rd) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rd_underflow: got=0x%0h expected=none at %0t", o_rd_data, $time);
        end else begin
          exp_px = sb.pop_front();
          total--;
          chk("rd_data", 32'(o_rd_data), 32'(exp_px));
        end
      end
      prev_stall = o_rd_valid && !i_rd_ready;
      prev_data  = o_rd_data;
      mcount     = mcount + int'(wr) - int'(rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst      = 1'b1;
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int bound);
    int n;
    n = 0;
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b1;
    while ((o_count != 9'd0 || o_rd_valid) && n < bound) begin
      tick();
      n++;
    end
    chk(name, 32'(o_count), 32'd0);
    chk({name, "_valid"}, 32'(o_rd_valid), 32'd0);
  endtask

  task automatic write_seq(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = 12'(base + i);
      tick();
    end
    i_wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int accepted, cyc;
    logic acc;
    i_rst      = 1'b1;
    i_wr_valid = 1'b0;
    i_wr_data  = '0;
    i_rd_ready = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(o_wr_ready), 32'd1);
    chk("rst_ram_we", 32'(o_ram_we), 32'd0);
    chk("rst_ram_re", 32'(o_ram_re), 32'd0);
    chk("rst_waddr", 32'(o_ram_waddr), 32'd0);
    chk("rst_raddr", 32'(o_ram_raddr), 32'd0);
`ifdef PIXEL_FIFO_ALMOST_FULL_EN
    chk("rst_almost_full", 32'(o_almost_full), 32'd0);
`endif
    i_rst = 1'b0;

    // Single pixel latency: write at N, valid at N+2, empty at N+3
    i_rd_ready = 1'b1;
    i_wr_valid = 1'b1;
    i_wr_data  = 12'hABC;
    chk("lat_ram_re_n", 32'(o_ram_re), 32'd0);
    tick();
    i_wr_valid = 1'b0;
    chk("lat_n1_valid", 32'(o_rd_valid), 32'd0);
    chk("lat_n1_re", 32'(o_ram_re), 32'd1);
    tick();
    chk("lat_n2_valid", 32'(o_rd_valid), 32'd1);
    chk("lat_n2_data", 32'(o_rd_data), 32'hABC);
    tick();
    chk("lat_n3_count", 32'(o_count), 32'd0);
    chk("lat_n3_valid", 32'(o_rd_valid), 32'd0);

    // Fill to 256, extra write refused, ordered drain
    i_rd_ready = 1'b0;
    write_seq(256, 0);
    chk("full_count", 32'(o_count), 32'd256);
    chk("full_wr_ready", 32'(o_wr_ready), 32'd0);
    i_wr_valid = 1'b1;
    i_wr_data  = 12'hFFF;
    tick();
    i_wr_valid = 1'b0;
    chk("full_257_count", 32'(o_count), 32'd256);
    wait_empty("drain_full", 400);

    // Full FIFO with continuous read and write across pointer wrap
    i_rd_ready = 1'b0;
    write_seq(256, 12'h200);
    chk("stream_full", 32'(o_count), 32'd256);
    for (int k = 0; k < 300; k++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = 12'(12'h400 + k);
      i_rd_ready = 1'b1;
      chk("stream_rd_valid", 32'(o_rd_valid), 32'd1);
      if (k > 0) chk("stream_count", 32'(o_count), 32'd255);
      tick();
    end
    wait_empty("drain_stream", 400);

    // Random consumer stalls over 1000 pixels
    accepted = 0;
    cyc      = 0;
    while (accepted < 1000 && cyc < 5000) begin
      i_wr_valid = 1'b1;
      i_wr_data  = 12'(accepted * 37 + 5);
      i_rd_ready = 1'($urandom_range(0, 1));
      acc        = o_wr_ready;
      tick();
      if (acc) accepted++;
      cyc++;
    end
    chk("rand_accepted", 32'(accepted), 32'd1000);
    wait_empty("drain_rand", 3000);

    // Reset with 100 stored and a fetch in flight
    i_rd_ready = 1'b0;
    write_seq(101, 12'h700);
    tick();
    i_rd_ready = 1'b1;
    tick();
    i_rd_ready = 1'b0;
    chk("mid_count_pre", 32'(o_count), 32'd100);
    chk("mid_valid_pre", 32'(o_rd_valid), 32'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("mid_count_post", 32'(o_count), 32'd0);
    chk("mid_valid_post", 32'(o_rd_valid), 32'd0);
    i_rd_ready = 1'b1;
    i_wr_valid = 1'b1;
    i_wr_data  = 12'h123;
    tick();
    i_wr_valid = 1'b0;
    tick();
    chk("mid_first_valid", 32'(o_rd_valid), 32'd1);
    chk("mid_first_data", 32'(o_rd_data), 32'h123);
    wait_empty("drain_mid", 10);

`ifdef PIXEL_FIFO_ALMOST_FULL_EN
    do_reset();
    write_seq(239, 0);
    tick();
    chk("af_239_count", 32'(o_count), 32'd239);
    chk("af_239", 32'(o_almost_full), 32'd0);
    write_seq(1, 239);
    chk("af_240_count", 32'(o_count), 32'd240);
    chk("af_240_same", 32'(o_almost_full), 32'd0);
    tick();
    chk("af_240_next", 32'(o_almost_full), 32'd1);
    wait_empty("drain_af", 400);
`endif

    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_fifo_ctrl.md
PIXEL_FIFO_CTRL -- requirements
Module: pixel_fifo_ctrl

Interface
REQ-001 SHALL have parameter ALMOST_FULL_THRESH, default 240, meaning the occupancy at or above which o_almost_full asserts (legal range 1..256).
REQ-002 SHALL have i_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have i_wr_valid  input  1  producer offers a 12-bit pixel.
REQ-005 SHALL have i_wr_data  input  12  pixel from producer.
REQ-006 SHALL have o_wr_ready  output  1  FIFO accepts a pixel this cycle.
REQ-007 SHALL have o_rd_valid  output  1  o_rd_data holds the oldest pixel.
REQ-008 SHALL have o_rd_data  output  12  oldest pixel.
REQ-009 SHALL have i_rd_ready  input  1  consumer takes the pixel this cycle.
REQ-010 SHALL have o_ram_we, o_ram_waddr[7:0], o_ram_wdata[11:0]  outputs  write port to the 256x12 EBR.
REQ-011 SHALL have o_ram_re, o_ram_raddr[7:0]  outputs; i_ram_rdata[11:0] input  read port to the EBR (1-cycle latency, RDATA held while RE low).
REQ-012 SHALL have o_count  output  9  occupancy, 0..256.
REQ-013 SHALL have o_almost_full  output  1  only when PIXEL_FIFO_ALMOST_FULL_EN is defined.

Function
REQ-014 Write handshake = i_wr_valid & o_wr_ready; read handshake = o_rd_valid & i_rd_ready.
REQ-015 o_wr_ready SHALL be combinationally (o_count != 256); no write while full, even if a read handshake occurs that cycle.
REQ-016 On write handshake: o_ram_we=1, o_ram_waddr=wptr[7:0], o_ram_wdata=i_wr_data same cycle; 9-bit wptr increments, wrapping 255->0 on the low 8 bits.
REQ-017 Occupancy SHALL increment on write handshake, decrement on read handshake, unchanged when both occur; a slot is freed only on read handshake.
REQ-018 Read stage SHALL be a 3-state FSM: IDLE (nothing fetched), FETCH (EBR read issued last cycle... data arrives), HOLD (o_rd_valid=1, awaiting i_rd_ready).
REQ-019 A fetch (o_ram_re=1, o_ram_raddr=fptr[7:0], fptr increments) SHALL issue only when an unfetched entry was written in an earlier cycle, and the stage is IDLE, or HOLD with read handshake this cycle.
REQ-020 No fetch SHALL target an address written in the same cycle (no read-during-write bypass).
REQ-021 o_rd_valid SHALL be 1 in the cycle after a fetch and while HOLD; o_rd_data = i_ram_rdata (EBR output held).
REQ-022 Latency: write handshake in cycle N into empty FIFO -> o_rd_valid=1 in cycle N+2.
REQ-023 Throughput: with continuous writes and i_rd_ready=1, one read handshake per cycle steady-state.
REQ-024 o_rd_data SHALL stay stable while o_rd_valid=1 and i_rd_ready=0.
REQ-025 Empty: o_rd_valid=0, no fetch; simultaneous write into empty SHALL not pass data through combinationally.

Reset
REQ-026 While i_rst=1 at a rising edge: wptr, fptr, occupancy, FSM cleared (IDLE); next cycle o_count=0, o_rd_valid=0, o_wr_ready=1, o_ram_we=0, o_ram_re=0, o_almost_full=0.
REQ-027 i_rst SHALL override any handshake in the same cycle; mid-operation reset discards all stored and in-flight pixels, EBR contents untouched.
REQ-028 Outputs o_ram_waddr/o_ram_raddr SHALL read 0 after reset; o_rd_data is don't-care while o_rd_valid=0.

Configuration
REQ-029 Macro PIXEL_FIFO_ALMOST_FULL_EN defined: o_almost_full port exists, registered, = (occupancy >= ALMOST_FULL_THRESH) updated each edge (one cycle behind o_count).
REQ-030 Macro undefined: port and its logic absent; all other behaviour identical.

Verification
REQ-031 Reset, write 0xABC at cycle N, i_rd_ready=1 -> o_rd_valid=1, o_rd_data=0xABC at N+2, o_count back to 0 at N+3.
REQ-032 Write 256 pixels 0x000..0x0FF, i_rd_ready=0 -> o_count=256, o_wr_ready=0; 257th write ignored; read-out yields 0x000..0x0FF in order.
REQ-033 Fill to 256, then i_wr_valid=1 and i_rd_ready=1 continuously -> reads every cycle, one write each cycle after a slot frees, data order preserved across pointer wrap.
REQ-034 i_rd_ready toggled randomly 50% with o_rd_valid=1 -> o_rd_data constant while stalled; no loss/duplication over 1000 pixels.
REQ-035 Assert i_rst with o_count=100 and a fetch in flight -> next cycle o_count=0, o_rd_valid=0; subsequent write 0x123 emerges first.
REQ-036 With PIXEL_FIFO_ALMOST_FULL_EN, default threshold: 239 writes -> o_almost_full=0; 240th -> o_almost_full=1 the cycle after o_count=240.
